// File: rtl/mem_stack_ctrl.sv
// Memory-port arbiter and stack-access sequencer for the shared 256x8 data/stack RAM.
// Define STACK_GUARD_EN to enable stack/data-region bounds checking and the sticky fault register.
module mem_stack_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_req,
    output logic       fetch_gnt,
    input  logic       op_valid,
    input  logic [2:0] op_code,
    input  logic [7:0] op_addr,
    input  logic [7:0] sp_in,
    output logic       stall,
    output logic       op_done,
    output logic       mem_en,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] stack_ctrl,
    output logic [7:0] mem_addr,
    output logic [1:0] wdata_sel,
    output logic       sp_we,
    output logic [7:0] sp_next,
    output logic [1:0] fault
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_e;
    typedef enum logic [2:0] {
        OP_LOAD, OP_STORE, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_INTR, OP_RTI
    } op_e;

    state_e     state_q, state_d;
    op_e        code_q, code_d;
    logic [7:0] sp_q, sp_d;
    logic       en_q, en_d, rd_q, rd_d, wr_q, wr_d, we_q, we_d, done_q, done_d;
    logic [3:0] sc_q, sc_d;
    logic [7:0] addr_q, addr_d, spn_q, spn_d;
    logic [1:0] ws_q, ws_d, fault_d;
    logic       viol_stack, viol_data;

`ifdef STACK_GUARD_EN
    localparam logic [8:0] SP_TOP    = 9'd255;
    localparam logic [8:0] SP_BOTTOM = 9'd200;
    localparam logic [7:0] DATA_LO   = 8'd156;
    localparam logic [7:0] DATA_HI   = 8'd199;

    logic       push_op, pop_op, ls_op;
    logic [8:0] n_acc;
    logic [1:0] fault_q;

    // Bounds are judged on the incoming request; 9-bit sums keep wrap from hiding a violation.
    always_comb begin
        push_op    = op_code inside {OP_PUSH, OP_CALL, OP_INTR};
        pop_op     = op_code inside {OP_POP, OP_RET, OP_RTI};
        ls_op      = op_code inside {OP_LOAD, OP_STORE};
        n_acc      = (op_code inside {OP_INTR, OP_RTI}) ? 9'd2 : 9'd1;
        viol_stack = (push_op && ({1'b0, sp_in} < SP_BOTTOM + n_acc)) ||
                     (pop_op  && ({1'b0, sp_in} + n_acc > SP_TOP));
        viol_data  = ls_op && ((op_addr < DATA_LO) || (op_addr > DATA_HI));
    end
    assign fault = fault_q;
`else
    assign viol_stack = 1'b0;
    assign viol_data  = 1'b0;
    assign fault      = 2'b00;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        code_d  = code_q;
        sp_d    = sp_q;
        en_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        sc_d    = 4'b0000;
        addr_d  = 8'd0;
        spn_d   = 8'd0;
        ws_d    = 2'b00;
        fault_d = fault;
        case (state_q)
            IDLE: if (op_valid) begin
                code_d  = op_e'(op_code);
                sp_d    = sp_in;
                state_d = ACC1;
                en_d    = 1'b1;
                case (op_e'(op_code))
                    OP_LOAD:  begin rd_d = 1'b1; addr_d = op_addr; done_d = 1'b1; end
                    OP_STORE: begin wr_d = 1'b1; addr_d = op_addr; done_d = 1'b1; end
                    OP_PUSH, OP_CALL: begin
                        wr_d   = 1'b1;
                        addr_d = sp_in;
                        sc_d   = (op_code == OP_PUSH) ? 4'b0001 : 4'b0011;
                        ws_d   = (op_code == OP_PUSH) ? 2'b00 : 2'b01;
                        we_d   = 1'b1;
                        spn_d  = sp_in - 8'd1;
                        done_d = 1'b1;
                    end
                    OP_POP, OP_RET: begin
                        rd_d   = 1'b1;
                        addr_d = sp_in + 8'd1;
                        sc_d   = (op_code == OP_POP) ? 4'b0010 : 4'b0100;
                        we_d   = 1'b1;
                        spn_d  = sp_in + 8'd1;
                        done_d = 1'b1;
                    end
                    OP_INTR: begin wr_d = 1'b1; addr_d = sp_in; sc_d = 4'b0110; ws_d = 2'b01; end
                    default: begin rd_d = 1'b1; addr_d = sp_in + 8'd1; sc_d = 4'b0101; end
                endcase
                // A violating request burns ACC1 with no access and finishes there.
                if (viol_stack || viol_data) begin
                    en_d    = 1'b0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    we_d    = 1'b0;
                    sc_d    = 4'b0000;
                    addr_d  = 8'd0;
                    spn_d   = 8'd0;
                    ws_d    = 2'b00;
                    done_d  = 1'b1;
                    fault_d = fault | {viol_data, viol_stack};
                end
            end
            ACC1: begin
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACC2;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    if (code_q == OP_INTR) begin
                        wr_d   = 1'b1;
                        addr_d = sp_q - 8'd1;
                        sc_d   = 4'b0111;
                        ws_d   = 2'b10;
                        spn_d  = sp_q - 8'd2;
                    end else begin
                        rd_d   = 1'b1;
                        addr_d = sp_q + 8'd2;
                        sc_d   = 4'b0100;
                        spn_d  = sp_q + 8'd2;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= OP_LOAD;
            sp_q    <= 8'd0;
            en_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            sc_q    <= 4'b0000;
            addr_q  <= 8'd0;
            spn_q   <= 8'd0;
            ws_q    <= 2'b00;
`ifdef STACK_GUARD_EN
            fault_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            sp_q    <= sp_d;
            en_q    <= en_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            we_q    <= we_d;
            done_q  <= done_d;
            sc_q    <= sc_d;
            addr_q  <= addr_d;
            spn_q   <= spn_d;
            ws_q    <= ws_d;
`ifdef STACK_GUARD_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign fetch_gnt  = fetch_req && (state_q == IDLE) && !op_valid;
    assign stall      = op_valid && !done_q;
    assign op_done    = done_q;
    assign mem_en     = en_q;
    assign mem_read   = rd_q;
    assign mem_write  = wr_q;
    assign stack_ctrl = sc_q;
    assign mem_addr   = addr_q;
    assign wdata_sel  = ws_q;
    assign sp_we      = we_q;
    assign sp_next    = spn_q;

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Table-driven bench for mem_stack_ctrl; expectations follow STACK_GUARD_EN when defined.
module tb_mem_stack_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch_req = 1'b0;
    logic       op_valid = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic [7:0] op_addr = 8'd0;
    logic [7:0] sp_in = 8'd0;
    logic       fetch_gnt, stall, op_done, mem_en, mem_read, mem_write, sp_we;
    logic [3:0] stack_ctrl;
    logic [7:0] mem_addr, sp_next;
    logic [1:0] wdata_sel, fault;

    int errors = 0;
    int checks = 0;

    mem_stack_ctrl dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_gnt(fetch_gnt),
        .op_valid(op_valid), .op_code(op_code), .op_addr(op_addr), .sp_in(sp_in),
        .stall(stall), .op_done(op_done), .mem_en(mem_en), .mem_read(mem_read),
        .mem_write(mem_write), .stack_ctrl(stack_ctrl), .mem_addr(mem_addr),
        .wdata_sel(wdata_sel), .sp_we(sp_we), .sp_next(sp_next), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en, rd, wr;
        logic [7:0] addr;
        logic [3:0] sc;
        logic [1:0] ws;
        logic       we;
        logic [7:0] spn;
        logic       done;
    } out_t;

    typedef struct {
        logic [2:0] code;
        logic [7:0] addr;
        logic [7:0] sp;
        bit         two;
        out_t       a1;
        out_t       a2;
        logic [1:0] flt;
    } vec_t;

    vec_t vecs[$];

    function automatic out_t o(input logic en, rd, wr, input logic [7:0] addr,
                               input logic [3:0] sc, input logic [1:0] ws,
                               input logic we, input logic [7:0] spn, input logic done);
        o = '{en: en, rd: rd, wr: wr, addr: addr, sc: sc, ws: ws, we: we, spn: spn, done: done};
    endfunction

    function automatic out_t cur();
        cur = '{en: mem_en, rd: mem_read, wr: mem_write, addr: mem_addr, sc: stack_ctrl,
                ws: wdata_sel, we: sp_we, spn: sp_next, done: op_done};
    endfunction

    task automatic add(input logic [2:0] code, input logic [7:0] addr, input logic [7:0] sp,
                       input bit two, input out_t a1, input out_t a2, input logic [1:0] flt);
        vec_t v;
        v.code = code; v.addr = addr; v.sp = sp; v.two = two;
        v.a1 = a1; v.a2 = a2; v.flt = flt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        out_t z, done_only;
        z = '0;
        done_only = o(0, 0, 0, 8'd0, 4'd0, 2'd0, 0, 8'd0, 1);

        // code addr sp two acc1 acc2 fault
        add(3'd2, 8'd0,   8'd255, 0, o(1,0,1,8'd255,4'd1,2'd0,1,8'd254,1), z, 2'b00);  // PUSH
        add(3'd6, 8'd0,   8'd250, 1, o(1,0,1,8'd250,4'd6,2'd1,0,8'd0,0),
                                     o(1,0,1,8'd249,4'd7,2'd2,1,8'd248,1), 2'b00);      // INTR
        add(3'd7, 8'd0,   8'd248, 1, o(1,1,0,8'd249,4'd5,2'd0,0,8'd0,0),
                                     o(1,1,0,8'd250,4'd4,2'd0,1,8'd250,1), 2'b00);      // RTI
        add(3'd1, 8'd170, 8'd9,   0, o(1,0,1,8'd170,4'd0,2'd0,0,8'd0,1), z, 2'b00);     // STORE
        add(3'd0, 8'd156, 8'd9,   0, o(1,1,0,8'd156,4'd0,2'd0,0,8'd0,1), z, 2'b00);     // LOAD lo edge
        add(3'd0, 8'd199, 8'd9,   0, o(1,1,0,8'd199,4'd0,2'd0,0,8'd0,1), z, 2'b00);     // LOAD hi edge
        add(3'd4, 8'd0,   8'd230, 0, o(1,0,1,8'd230,4'd3,2'd1,1,8'd229,1), z, 2'b00);  // CALL
        add(3'd5, 8'd0,   8'd229, 0, o(1,1,0,8'd230,4'd4,2'd0,1,8'd230,1), z, 2'b00);  // RET
        add(3'd3, 8'd0,   8'd254, 0, o(1,1,0,8'd255,4'd2,2'd0,1,8'd255,1), z, 2'b00);  // POP to top
        add(3'd2, 8'd0,   8'd201, 0, o(1,0,1,8'd201,4'd1,2'd0,1,8'd200,1), z, 2'b00);  // PUSH to bottom
`ifdef STACK_GUARD_EN
        add(3'd3, 8'd0,   8'd255, 0, done_only, z, 2'b01);                              // POP underflow
        add(3'd1, 8'd50,  8'd9,   0, done_only, z, 2'b11);                              // STORE out of region
        add(3'd2, 8'd0,   8'd200, 0, done_only, z, 2'b11);                              // PUSH overflow
        add(3'd6, 8'd0,   8'd201, 0, done_only, z, 2'b11);                              // INTR overflow
`else
        add(3'd3, 8'd0,   8'd255, 0, o(1,1,0,8'd0,4'd2,2'd0,1,8'd0,1), z, 2'b00);
        add(3'd1, 8'd50,  8'd9,   0, o(1,0,1,8'd50,4'd0,2'd0,0,8'd0,1), z, 2'b00);
        add(3'd2, 8'd0,   8'd200, 0, o(1,0,1,8'd200,4'd1,2'd0,1,8'd199,1), z, 2'b00);
        add(3'd6, 8'd0,   8'd201, 1, o(1,0,1,8'd201,4'd6,2'd1,0,8'd0,0),
                                     o(1,0,1,8'd200,4'd7,2'd2,1,8'd199,1), 2'b00);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(cur()), 32'(z));
        check("reset_fault", 32'(fault), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            check($sformatf("v%0d_idle", i), 32'(cur()), 32'(z));
            op_valid = 1'b1;
            op_code  = vecs[i].code;
            op_addr  = vecs[i].addr;
            sp_in    = vecs[i].sp;
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_acc1", i), 32'(cur()), 32'(vecs[i].a1));
            check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
            if (vecs[i].two) begin
                @(negedge clk);
                check($sformatf("v%0d_acc2", i), 32'(cur()), 32'(vecs[i].a2));
            end
            op_valid = 1'b0;
        end

        // Arbitration: MEM request beats fetch, fetch granted after the op
        @(negedge clk);
        fetch_req = 1'b1;
        #1;
        check("fetch_alone_gnt", 32'(fetch_gnt), 32'd1);
        op_valid = 1'b1; op_code = 3'd0; op_addr = 8'd160;
        #1;
        check("arb_gnt_low", 32'(fetch_gnt), 32'd0);
        check("arb_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check("arb_load", 32'({mem_read, mem_addr, op_done}), 32'({1'b1, 8'd160, 1'b1}));
        check("arb_gnt_acc1", 32'(fetch_gnt), 32'd0);
        check("arb_stall_done", 32'(stall), 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        check("arb_gnt_after", 32'(fetch_gnt), 32'd1);
        fetch_req = 1'b0;

        // Reset during INTR ACC1 discards the sequence
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd6; sp_in = 8'd250;
        @(negedge clk);
        check("rst_mid_acc1", 32'({mem_write, mem_addr}), 32'({1'b1, 8'd250}));
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 32'(cur()), 32'(z));
        check("rst_mid_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_acc2", 32'(cur()), 32'(z));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
